branch_resolve_ctrl: RTL and testbench

- Multicycle sequencer for conditional branches (BNE/BEQ/BLE/BGT).
- Drives the ALU through the target-compute and compare phases, selects the condition type for the condition-handler mux, and samples the selected flag (cond_in).
- Issues a gated PC write when the branch is taken.
- Sits between the main control FSM (start/done handshake) and the PC/ALUOut datapath.
- Keeps saturating branch/taken statistics counters.

---
 rtl/branch_resolve_ctrl_if.sv | 33 +++
 rtl/branch_resolve_ctrl.sv | 151 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Handshake and datapath-control bundle between the main control FSM,
// the branch resolve controller and the PC/ALUOut datapath.
interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       br_op;
    logic             cond_in;
    logic             flush;
    logic             clr_stats;
    logic [1:0]       cond_type;
    logic             alu_target;
    logic             aluout_load;
    logic             alu_cmp;
    logic             pc_write;
    logic             busy;
    logic             done;
    logic             taken;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output start, br_op, cond_in, flush, clr_stats,
        input  cond_type, alu_target, aluout_load, alu_cmp, pc_write,
        input  busy, done, taken, br_count, taken_count
    );

    modport slave (
        input  start, br_op, cond_in, flush, clr_stats,
        output cond_type, alu_target, aluout_load, alu_cmp, pc_write,
        output busy, done, taken, br_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Multicycle conditional-branch sequencer: target compute, compare, resolve,
// gated PC write, with saturating branch/taken statistics.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start from the main FSM
// S_TARGET  | ALU computes PC + (imm<<2), result latched into ALUOut
// S_COMPARE | ALU compares A-B for CMP_CYCLES cycles
// S_RESOLVE | flags held, cond_in sampled, PC written if taken
// S_DONE    | one-cycle done pulse back to the main FSM
module branch_resolve_ctrl #(
    parameter int CMP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TARGET  = 3'd1,
        S_COMPARE = 3'd2,
        S_RESOLVE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0]       CMP_LOAD = 4'(CMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q,       state_d;
    logic [1:0]       op_q,          op_d;
    logic [3:0]       cmp_cnt_q,     cmp_cnt_d;
    logic             taken_q,       taken_d;
    logic [CNT_W-1:0] br_count_q,    br_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;
    logic             alu_target_q,  alu_target_d;
    logic             alu_cmp_q,     alu_cmp_d;

    logic             resolve_fire;

    // A flushed RESOLVE cycle must leave taken and the counters untouched.
    assign resolve_fire = (state_q == S_RESOLVE) && !bus.flush;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cmp_cnt_d = cmp_cnt_q;
        taken_d   = taken_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_d    = bus.br_op;
                        state_d = S_TARGET;
                    end
                end
                S_TARGET: begin
                    cmp_cnt_d = CMP_LOAD;
                    state_d   = S_COMPARE;
                end
                S_COMPARE: begin
                    if (cmp_cnt_q == 4'd0) begin
                        state_d = S_RESOLVE;
                    end else begin
                        cmp_cnt_d = cmp_cnt_q - 4'd1;
                    end
                end
                S_RESOLVE: begin
                    taken_d = bus.cond_in;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;

        if (bus.clr_stats) begin
            br_count_d    = '0;
            taken_count_d = '0;
        end else if (resolve_fire) begin
            if (br_count_q != CNT_MAX) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if (bus.cond_in && (taken_count_q != CNT_MAX)) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end
    end

    // Moore outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        alu_target_d = (state_d == S_TARGET);
        alu_cmp_d    = (state_d == S_COMPARE) || (state_d == S_RESOLVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            cmp_cnt_q     <= 4'd0;
            taken_q       <= 1'b0;
            br_count_q    <= '0;
            taken_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            alu_target_q  <= 1'b0;
            alu_cmp_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cmp_cnt_q     <= cmp_cnt_d;
            taken_q       <= taken_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            alu_target_q  <= alu_target_d;
            alu_cmp_q     <= alu_cmp_d;
        end
    end

    assign bus.cond_type   = op_q;
    assign bus.alu_target  = alu_target_q;
    assign bus.aluout_load = alu_target_q;
    assign bus.alu_cmp     = alu_cmp_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.taken       = taken_q;
    assign bus.br_count    = br_count_q;
    assign bus.taken_count = taken_count_q;
    // The PC write is gated with reset so a reset cycle can never load the PC.
    assign bus.pc_write    = (state_q == S_RESOLVE) && bus.cond_in && !bus.flush && !reset;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: two instances (CMP_CYCLES=1/CNT_W=16 and
// CMP_CYCLES=3/CNT_W=4) share stimulus and are checked against a position model.
module tb_branch_resolve_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] br_op;
    logic       cond_in;
    logic       flush;
    logic       clr_stats;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.CNT_W(16)) bi1 ();
    branch_resolve_ctrl_if #(.CNT_W(4))  bi3 ();

    assign bi1.start = start;  assign bi1.br_op = br_op;  assign bi1.cond_in = cond_in;
    assign bi1.flush = flush;  assign bi1.clr_stats = clr_stats;
    assign bi3.start = start;  assign bi3.br_op = br_op;  assign bi3.cond_in = cond_in;
    assign bi3.flush = flush;  assign bi3.clr_stats = clr_stats;

    branch_resolve_ctrl #(.CMP_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(bi1));
    branch_resolve_ctrl #(.CMP_CYCLES(3), .CNT_W(4))  u3 (.clk(clk), .reset(reset), .bus(bi3));

    // Model: pos 0 = idle, 1 = target, 2..c+1 = compare, c+2 = resolve, c+3 = done.
    int         cmpc [2] = '{1, 3};
    int         cmax [2] = '{65535, 15};
    int         pos  [2];
    logic [1:0] m_op [2];
    logic       m_tk [2];
    int         m_bc [2];
    int         m_tc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_inst(input int i, input logic [1:0] ct, input logic at, input logic al,
                              input logic ac, input logic pw, input logic bs, input logic dn,
                              input logic tk, input logic [31:0] bc, input logic [31:0] tc);
        int c;
        int p;
        c = cmpc[i];
        p = pos[i];
        chk($sformatf("u%0d.cond_type", i),   32'(ct), 32'(m_op[i]));
        chk($sformatf("u%0d.alu_target", i),  32'(at), 32'(p == 1));
        chk($sformatf("u%0d.aluout_load", i), 32'(al), 32'(p == 1));
        chk($sformatf("u%0d.alu_cmp", i),     32'(ac), 32'(p >= 2 && p <= c + 2));
        chk($sformatf("u%0d.pc_write", i),    32'(pw), 32'(p == c + 2 && cond_in && !flush && !reset));
        chk($sformatf("u%0d.busy", i),        32'(bs), 32'(p != 0));
        chk($sformatf("u%0d.done", i),        32'(dn), 32'(p == c + 3));
        chk($sformatf("u%0d.taken", i),       32'(tk), 32'(m_tk[i]));
        chk($sformatf("u%0d.br_count", i),    bc, 32'(m_bc[i]));
        chk($sformatf("u%0d.taken_count", i), tc, 32'(m_tc[i]));
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int  c;
            logic res;
            c = cmpc[i];
            if (reset) begin
                pos[i] = 0; m_op[i] = 2'b00; m_tk[i] = 1'b0; m_bc[i] = 0; m_tc[i] = 0;
            end else begin
                res = (pos[i] == c + 2) && !flush;
                if (clr_stats) begin
                    m_bc[i] = 0; m_tc[i] = 0;
                end else if (res) begin
                    if (m_bc[i] < cmax[i]) m_bc[i]++;
                    if (cond_in && m_tc[i] < cmax[i]) m_tc[i]++;
                end
                if (res) m_tk[i] = cond_in;
                if (pos[i] == 0) begin
                    if (start && !flush) begin
                        m_op[i] = br_op; pos[i] = 1;
                    end
                end else if (flush || pos[i] == c + 3) begin
                    pos[i] = 0;
                end else begin
                    pos[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_inst(0, bi1.cond_type, bi1.alu_target, bi1.aluout_load, bi1.alu_cmp, bi1.pc_write,
                   bi1.busy, bi1.done, bi1.taken, 32'(bi1.br_count), 32'(bi1.taken_count));
        check_inst(1, bi3.cond_type, bi3.alu_target, bi3.aluout_load, bi3.alu_cmp, bi3.pc_write,
                   bi3.busy, bi3.done, bi3.taken, 32'(bi3.br_count), 32'(bi3.taken_count));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drv(input logic s, input logic [1:0] op, input logic c,
                       input logic f, input logic cl, input logic r);
        start = s; br_op = op; cond_in = c; flush = f; clr_stats = cl; reset = r;
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; br_op = 2'b00; cond_in = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        drv(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset.busy", 32'(bi1.busy), 32'd0);
        chk("reset.cond_type", 32'(bi1.cond_type), 32'd0);

        // BEQ taken
        drv(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq.taken", 32'(bi1.taken), 32'd1);
        chk("beq.br_count", 32'(bi1.br_count), 32'd1);
        chk("beq.taken_count", 32'(bi1.taken_count), 32'd1);

        // BGT not taken
        drv(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) drv(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bgt.cond_type", 32'(bi1.cond_type), 32'd3);
        chk("bgt.taken", 32'(bi1.taken), 32'd0);
        chk("bgt.br_count", 32'(bi1.br_count), 32'd2);
        chk("bgt.taken_count", 32'(bi1.taken_count), 32'd1);

        // BLE not taken, with an extra start while busy
        drv(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drv(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ble.u3_br_count", 32'(bi3.br_count), 32'd3);
        chk("ble.u1_br_count", 32'(bi1.br_count), 32'd3);

        // flush in u1's RESOLVE cycle with cond_in=1
        drv(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush.busy", 32'(bi1.busy), 32'd0);
        for (int k = 0; k < 3; k++) drv(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush.taken", 32'(bi1.taken), 32'd0);
        chk("flush.br_count", 32'(bi1.br_count), 32'd3);

        // 17 taken branches saturate the 4-bit counters
        for (int n = 0; n < 17; n++) begin
            drv(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("sat.br_count", 32'(bi3.br_count), 32'd15);
        chk("sat.taken_count", 32'(bi3.taken_count), 32'd15);
        chk("nosat.br_count", 32'(bi1.br_count), 32'd20);

        // clr_stats coincident with u3's RESOLVE
        drv(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr.br_count", 32'(bi3.br_count), 32'd0);
        chk("clr.taken_count", 32'(bi3.taken_count), 32'd0);

        // reset during COMPARE, then a normal branch
        drv(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst.busy", 32'(bi1.busy), 32'd0);
        chk("rst.cond_type", 32'(bi1.cond_type), 32'd0);
        drv(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) drv(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst.br_count", 32'(bi1.br_count), 32'd1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            drv(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
